// File: rtl/dram_cmd_ctrl_if.sv
// Request/response and SDRAM command-bus bundle for dram_cmd_ctrl.
//   master : requester side (L2 cache / environment), also supplies mem_dq_in
//   slave  : the command controller
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata  single-beat request handshake
//   rsp_valid/rsp_rdata                            read response
//   mem_cs_n/ras_n/cas_n/we_n, mem_addr, mem_ba    SDRAM command bus
//   mem_dq_out/mem_dq_oe/mem_dq_in                 SDRAM data pad
interface dram_cmd_ctrl_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BA_W   = 3,
   parameter int unsigned ROW_W  = 14
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              mem_cs_n;
   logic              mem_ras_n;
   logic              mem_cas_n;
   logic              mem_we_n;
   logic [ROW_W-1:0]  mem_addr;
   logic [BA_W-1:0]   mem_ba;
   logic [DATA_W-1:0] mem_dq_out;
   logic              mem_dq_oe;
   logic [DATA_W-1:0] mem_dq_in;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_dq_in,
      input  req_ready, rsp_valid, rsp_rdata, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n,
      input  mem_addr, mem_ba, mem_dq_out, mem_dq_oe
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_dq_in,
      output req_ready, rsp_valid, rsp_rdata, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n,
      output mem_addr, mem_ba, mem_dq_out, mem_dq_oe
   );
endinterface

// File: rtl/dram_cmd_ctrl.sv
// Main-memory command controller: turns single-beat read/write requests into
// ACT/READ/WRITE/PRE/REF sequences with an open-row policy per bank and
// periodic auto-refresh. All bus outputs are registered.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  dram_cmd_ctrl_if.slave: request/response handshake and SDRAM bus
module dram_cmd_ctrl #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned COL_W  = 10,
   parameter int unsigned BA_W   = 3,
   parameter int unsigned ROW_W  = 14,
   parameter int unsigned T_RCD  = 2,
   parameter int unsigned T_CL   = 2,
   parameter int unsigned T_RP   = 2,
   parameter int unsigned T_RFC  = 8,
   parameter int unsigned T_REFI = 780
) (
   input logic           clk,
   input logic           rst,
   dram_cmd_ctrl_if.slave bus
);
   localparam int unsigned OFF      = $clog2(DATA_W / 8);
   localparam int unsigned BANKS    = 2 ** BA_W;
   localparam int unsigned MAX_AB   = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int unsigned MAX_CD   = (T_RFC > T_CL) ? T_RFC : T_CL;
   localparam int unsigned WAIT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
   localparam int unsigned RCW      = $clog2(T_REFI);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CmdNop   = 4'b0111;
   localparam logic [3:0] CmdAct   = 4'b0011;
   localparam logic [3:0] CmdRead  = 4'b0101;
   localparam logic [3:0] CmdWrite = 4'b0100;
   localparam logic [3:0] CmdPre   = 4'b0010;
   localparam logic [3:0] CmdRef   = 4'b0001;

   localparam logic [ROW_W-1:0] PreaAddr = ROW_W'(1024);

   typedef enum logic [3:0] {
      StIdle, StPre, StAct, StWait, StRd, StRdLat, StWr, StWrData, StPrea, StRef
   } state_e;

   state_e                     state_q, wait_ret_q;
   logic [CNT_W-1:0]           wait_cnt_q;
   logic [RCW-1:0]             ref_cnt_q;
   logic                       ref_pending_q;
   logic [BANKS-1:0]           open_valid_q;
   logic [BANKS-1:0][ROW_W-1:0] open_row_q;

   logic                       we_q;
   logic [BA_W-1:0]            bank_q;
   logic [ROW_W-1:0]           row_q;
   logic [COL_W-1:0]           col_q;
   logic [DATA_W-1:0]          wdata_q;

   logic [3:0]                 cmd_q;
   logic [ROW_W-1:0]           mem_addr_q;
   logic [BA_W-1:0]            mem_ba_q;
   logic [DATA_W-1:0]          dq_out_q;
   logic                       dq_oe_q;
   logic                       rsp_valid_q;
   logic [DATA_W-1:0]          rsp_rdata_q;
   logic                       req_ready_q;

   logic [COL_W-1:0]           req_col;
   logic [BA_W-1:0]            req_bank;
   logic [ROW_W-1:0]           req_row;
   logic                       ref_expire;
   logic                       ref_pend_next;
   logic                       launch;
   state_e                     launch_st;
   logic [CNT_W-1:0]           dly;
   logic                       unused_addr;

   assign req_col  = bus.req_addr[OFF +: COL_W];
   assign req_bank = bus.req_addr[OFF + COL_W +: BA_W];
   assign req_row  = bus.req_addr[OFF + COL_W + BA_W +: ROW_W];
   // Address bits above the row field carry no meaning here.
   assign unused_addr = ^bus.req_addr;

   assign ref_expire    = (ref_cnt_q == RCW'(T_REFI - 1));
   assign ref_pend_next = ref_expire | ref_pending_q;

   // Timed states: either issue the follow-on command straight away (delay of
   // one cycle) or park in StWait; dly holds the StWait count (delay - 2).
   always_comb begin
      launch    = 1'b0;
      launch_st = StIdle;
      dly       = '0;
      case (state_q)
         StAct: begin
            launch    = (T_RCD == 1);
            launch_st = we_q ? StWr : StRd;
            dly       = CNT_W'(T_RCD - 2);
         end
         StPre: begin
            launch    = (T_RP == 1);
            launch_st = StAct;
            dly       = CNT_W'(T_RP - 2);
         end
         StPrea: begin
            launch    = (T_RP == 1);
            launch_st = StRef;
            dly       = CNT_W'(T_RP - 2);
         end
         StRef: begin
            launch    = (T_RFC == 1);
            launch_st = StIdle;
            dly       = CNT_W'(T_RFC - 2);
         end
         StWait: begin
            launch    = (wait_cnt_q == '0);
            launch_st = wait_ret_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         wait_ret_q    <= StIdle;
         wait_cnt_q    <= '0;
         ref_cnt_q     <= '0;
         ref_pending_q <= 1'b0;
         open_valid_q  <= '0;
         open_row_q    <= '0;
         we_q          <= 1'b0;
         bank_q        <= '0;
         row_q         <= '0;
         col_q         <= '0;
         wdata_q       <= '0;
         cmd_q         <= CmdNop;
         mem_addr_q    <= '0;
         mem_ba_q      <= '0;
         dq_out_q      <= '0;
         dq_oe_q       <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         req_ready_q   <= 1'b0;
      end else begin
         cmd_q       <= CmdNop;
         dq_oe_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b0;
         ref_cnt_q   <= ref_expire ? '0 : ref_cnt_q + 1'b1;

         case (state_q)
            StIdle: begin
               if (ref_pending_q) begin
                  ref_pending_q <= 1'b0;
                  open_valid_q  <= '0;
                  if (|open_valid_q) begin
                     state_q    <= StPrea;
                     cmd_q      <= CmdPre;
                     mem_addr_q <= PreaAddr;
                  end else begin
                     state_q <= StRef;
                     cmd_q   <= CmdRef;
                  end
               end else if (bus.req_valid && req_ready_q) begin
                  we_q     <= bus.req_we;
                  bank_q   <= req_bank;
                  row_q    <= req_row;
                  col_q    <= req_col;
                  wdata_q  <= bus.req_wdata;
                  mem_ba_q <= req_bank;
                  if (!open_valid_q[req_bank]) begin
                     state_q                <= StAct;
                     cmd_q                  <= CmdAct;
                     mem_addr_q             <= req_row;
                     open_valid_q[req_bank] <= 1'b1;
                     open_row_q[req_bank]   <= req_row;
                  end else if (open_row_q[req_bank] == req_row) begin
                     state_q    <= bus.req_we ? StWr : StRd;
                     cmd_q      <= bus.req_we ? CmdWrite : CmdRead;
                     mem_addr_q <= ROW_W'(req_col);
                  end else begin
                     // Single-bank precharge: addr[10] low.
                     state_q                <= StPre;
                     cmd_q                  <= CmdPre;
                     mem_addr_q             <= '0;
                     open_valid_q[req_bank] <= 1'b0;
                  end
               end else begin
                  req_ready_q <= ~ref_pend_next;
               end
            end
            StRd: begin
               state_q    <= StRdLat;
               wait_cnt_q <= CNT_W'(T_CL - 1);
            end
            StRdLat: begin
               if (wait_cnt_q == '0) begin
                  rsp_rdata_q <= bus.mem_dq_in;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StIdle;
                  req_ready_q <= ~ref_pend_next;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            StWr: begin
               state_q  <= StWrData;
               dq_oe_q  <= 1'b1;
               dq_out_q <= wdata_q;
            end
            StWrData: begin
               state_q     <= StIdle;
               req_ready_q <= ~ref_pend_next;
            end
            default: begin
               // StAct, StPre, StPrea, StRef, StWait
               if (launch) begin
                  state_q <= launch_st;
                  case (launch_st)
                     StAct: begin
                        cmd_q              <= CmdAct;
                        mem_addr_q         <= row_q;
                        mem_ba_q           <= bank_q;
                        open_valid_q[bank_q] <= 1'b1;
                        open_row_q[bank_q]   <= row_q;
                     end
                     StRd: begin
                        cmd_q      <= CmdRead;
                        mem_addr_q <= ROW_W'(col_q);
                        mem_ba_q   <= bank_q;
                     end
                     StWr: begin
                        cmd_q      <= CmdWrite;
                        mem_addr_q <= ROW_W'(col_q);
                        mem_ba_q   <= bank_q;
                     end
                     StRef:   cmd_q       <= CmdRef;
                     StIdle:  req_ready_q <= ~ref_pend_next;
                     default: ;
                  endcase
               end else if (state_q != StWait) begin
                  state_q    <= StWait;
                  wait_cnt_q <= dly;
                  wait_ret_q <= launch_st;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
         endcase

         // An expiry always wins over a clear; a second expiry is absorbed.
         if (ref_expire) ref_pending_q <= 1'b1;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.mem_cs_n   = cmd_q[3];
   assign bus.mem_ras_n  = cmd_q[2];
   assign bus.mem_cas_n  = cmd_q[1];
   assign bus.mem_we_n   = cmd_q[0];
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_ba     = mem_ba_q;
   assign bus.mem_dq_out = dq_out_q;
   assign bus.mem_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_dram_cmd_ctrl.sv
// Directed bench for dram_cmd_ctrl: table of single transactions on a default
// instance, plus hand-written refresh (short T_REFI instance) and reset cases.
module tb_dram_cmd_ctrl;
   localparam logic [3:0] CmdNop   = 4'b0111;
   localparam logic [3:0] CmdAct   = 4'b0011;
   localparam logic [3:0] CmdRead  = 4'b0101;
   localparam logic [3:0] CmdWrite = 4'b0100;
   localparam logic [3:0] CmdPre   = 4'b0010;
   localparam logic [3:0] CmdRef   = 4'b0001;

   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   dram_cmd_ctrl_if #(.DATA_W(64), .BA_W(3), .ROW_W(14)) if0 ();
   dram_cmd_ctrl_if #(.DATA_W(64), .BA_W(3), .ROW_W(14)) if1 ();

   dram_cmd_ctrl dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
   dram_cmd_ctrl #(.T_REFI(20)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

   logic [3:0] cmd0, cmd1;
   assign cmd0 = {if0.mem_cs_n, if0.mem_ras_n, if0.mem_cas_n, if0.mem_we_n};
   assign cmd1 = {if1.mem_cs_n, if1.mem_ras_n, if1.mem_cas_n, if1.mem_we_n};

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [3:0]  first_cmd;
      logic [13:0] first_addr;
      logic [2:0]  ba;
      int          act_cyc;   // 0 = no ACT expected
      int          rw_cyc;
      logic [13:0] col;
      int          rsp_cyc;   // 0 = no response
      int          oe_cyc;    // 0 = no write data
      int          rdy_cyc;
   } vec_t;

   vec_t vecs [5];
   int   checks   = 0;
   int   failures = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic wait_ready(input int which, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if ((which == 0) ? if0.req_ready : if1.req_ready) begin
            ok = 1;
            break;
         end
         step();
      end
      check($sformatf("wait_ready%0d", which), 64'(ok), 64'd1);
   endtask

   task automatic run_vec(input int k);
      vec_t        v = vecs[k];
      int          act_c = 0, rw_c = 0, rsp_c = 0, oe_c = 0, oe_n = 0, rdy_c = 0;
      logic [13:0] rw_addr = '0;
      logic [63:0] rsp_data = '0, oe_data = '0;
      wait_ready(0, 50);
      if0.req_valid = 1'b1;
      if0.req_we    = v.we;
      if0.req_addr  = v.addr;
      if0.req_wdata = v.wdata;
      step();
      if0.req_valid = 1'b0;
      check($sformatf("v%0d_first_cmd", k), 64'(cmd0), 64'(v.first_cmd));
      check($sformatf("v%0d_first_addr", k), 64'(if0.mem_addr), 64'(v.first_addr));
      check($sformatf("v%0d_first_ba", k), 64'(if0.mem_ba), 64'(v.ba));
      for (int c = 1; c <= 12; c++) begin
         if (cmd0 == CmdAct && act_c == 0) act_c = c;
         if ((cmd0 == CmdRead || cmd0 == CmdWrite) && rw_c == 0) begin
            rw_c    = c;
            rw_addr = if0.mem_addr;
         end
         if (if0.rsp_valid && rsp_c == 0) begin
            rsp_c    = c;
            rsp_data = if0.rsp_rdata;
         end
         if (if0.mem_dq_oe) begin
            oe_n++;
            if (oe_c == 0) begin
               oe_c    = c;
               oe_data = if0.mem_dq_out;
            end
         end
         if (if0.req_ready && rdy_c == 0) rdy_c = c;
         if0.mem_dq_in = (v.rsp_cyc != 0 && c == v.rsp_cyc - 1) ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
         step();
      end
      check($sformatf("v%0d_act_cycle", k), 64'(act_c), 64'(v.act_cyc));
      check($sformatf("v%0d_rw_cycle", k), 64'(rw_c), 64'(v.rw_cyc));
      check($sformatf("v%0d_rw_col", k), 64'(rw_addr), 64'(v.col));
      check($sformatf("v%0d_rsp_cycle", k), 64'(rsp_c), 64'(v.rsp_cyc));
      check($sformatf("v%0d_oe_count", k), 64'(oe_n), v.we ? 64'd1 : 64'd0);
      if (v.we) begin
         check($sformatf("v%0d_oe_cycle", k), 64'(oe_c), 64'(v.oe_cyc));
         check($sformatf("v%0d_dq_out", k), oe_data, v.wdata);
      end else begin
         check($sformatf("v%0d_rsp_data", k), rsp_data, v.rdata);
      end
      check($sformatf("v%0d_ready_cycle", k), 64'(rdy_c), 64'(v.rdy_cyc));
   endtask

   initial begin
      int p, f, a, r, seen;
      logic        pa10;
      logic [13:0] a_addr;
      logic [2:0]  a_ba;
      bit          ok;

      vecs[0] = '{we: 1'b0, addr: 32'h0003_2048, wdata: 64'h0, rdata: 64'hDEAD_BEEF_0000_0001,
                  first_cmd: CmdAct, first_addr: 14'd3, ba: 3'd1, act_cyc: 1, rw_cyc: 3,
                  col: 14'd9, rsp_cyc: 6, oe_cyc: 0, rdy_cyc: 6};
      vecs[1] = '{we: 1'b0, addr: 32'h0003_2048, wdata: 64'h0, rdata: 64'hA5A5_0000_1234_5678,
                  first_cmd: CmdRead, first_addr: 14'd9, ba: 3'd1, act_cyc: 0, rw_cyc: 1,
                  col: 14'd9, rsp_cyc: 4, oe_cyc: 0, rdy_cyc: 4};
      vecs[2] = '{we: 1'b0, addr: 32'h0004_2048, wdata: 64'h0, rdata: 64'h0123_4567_89AB_CDEF,
                  first_cmd: CmdPre, first_addr: 14'd0, ba: 3'd1, act_cyc: 3, rw_cyc: 5,
                  col: 14'd9, rsp_cyc: 8, oe_cyc: 0, rdy_cyc: 8};
      vecs[3] = '{we: 1'b1, addr: 32'h0004_2050, wdata: 64'h1122_3344_5566_7788, rdata: 64'h0,
                  first_cmd: CmdWrite, first_addr: 14'd10, ba: 3'd1, act_cyc: 0, rw_cyc: 1,
                  col: 14'd10, rsp_cyc: 0, oe_cyc: 2, rdy_cyc: 3};
      vecs[4] = '{we: 1'b0, addr: 32'h0004_2048, wdata: 64'h0, rdata: 64'h0F0F_F0F0_5555_AAAA,
                  first_cmd: CmdAct, first_addr: 14'd4, ba: 3'd1, act_cyc: 1, rw_cyc: 3,
                  col: 14'd9, rsp_cyc: 6, oe_cyc: 0, rdy_cyc: 6};

      rst0 = 1'b1;
      rst1 = 1'b1;
      if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
      if0.mem_dq_in = '0;
      if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
      if1.mem_dq_in = 64'h5A5A_5A5A_5A5A_5A5A;

      // Reset values.
      step(); step(); step();
      check("rst_cmd", 64'(cmd0), 64'(CmdNop));
      check("rst_addr", 64'(if0.mem_addr), 64'd0);
      check("rst_ba", 64'(if0.mem_ba), 64'd0);
      check("rst_dq_out", if0.mem_dq_out, 64'd0);
      check("rst_dq_oe", 64'(if0.mem_dq_oe), 64'd0);
      check("rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
      check("rst_rsp_rdata", if0.rsp_rdata, 64'd0);
      check("rst_ready", 64'(if0.req_ready), 64'd0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      #1;
      check("release_ready_same_cycle", 64'(if0.req_ready), 64'd0);
      step();
      check("release_ready_next_cycle", 64'(if0.req_ready), 64'd1);

      // Refresh on the T_REFI=20 instance: open bank 1 first.
      wait_ready(1, 20);
      if1.req_valid = 1'b1;
      if1.req_we    = 1'b0;
      if1.req_addr  = 32'h0003_2048;
      step();
      if1.req_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (if1.rsp_valid) begin
            ok = 1;
            break;
         end
         step();
      end
      check("ref_setup_rsp", 64'(ok), 64'd1);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (!if1.req_ready) begin
            ok = 1;
            break;
         end
         step();
      end
      check("ref_ready_drop", 64'(ok), 64'd1);
      // Request arrives while the refresh is pending and is held high.
      if1.req_valid = 1'b1;
      if1.req_addr  = 32'h0003_2048;
      p = 0; f = 0; a = 0; r = 0; pa10 = 1'b0; a_addr = '0; a_ba = '0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (cmd1 == CmdPre && p == 0) begin
            p    = c;
            pa10 = if1.mem_addr[10];
         end
         if (cmd1 == CmdRef && f == 0) f = c;
         if (cmd1 == CmdAct && a == 0) begin
            a      = c;
            a_addr = if1.mem_addr;
            a_ba   = if1.mem_ba;
         end
         if (if1.req_ready && r == 0) r = c;
         if (r != 0 && c > r) if1.req_valid = 1'b0;
      end
      if1.req_valid = 1'b0;
      check("ref_prea_cycle", 64'(p), 64'd1);
      check("ref_prea_a10", 64'(pa10), 64'd1);
      check("ref_prea_to_ref", 64'(f - p), 64'd2);
      check("ref_ready_cycle", 64'(r - f), 64'd8);
      check("ref_ref_to_act", 64'(a - f), 64'd9);
      check("ref_act_row", 64'(a_addr), 64'd3);
      check("ref_act_ba", 64'(a_ba), 64'd1);

      // Closed, hit, conflict, write on the default instance.
      for (int k = 0; k < 4; k++) run_vec(k);

      // Reset during RD_LAT of a hit read.
      wait_ready(0, 20);
      if0.req_valid = 1'b1;
      if0.req_we    = 1'b0;
      if0.req_addr  = 32'h0004_2048;
      step();
      if0.req_valid = 1'b0;
      check("abort_read_cmd", 64'(cmd0), 64'(CmdRead));
      step();
      if0.mem_dq_in = 64'hFEED_FACE_CAFE_F00D;
      rst0 = 1'b1;
      #1;
      check("abort_cmd", 64'(cmd0), 64'(CmdNop));
      check("abort_oe", 64'(if0.mem_dq_oe), 64'd0);
      check("abort_rsp_valid", 64'(if0.rsp_valid), 64'd0);
      check("abort_rsp_rdata", if0.rsp_rdata, 64'd0);
      check("abort_ready", 64'(if0.req_ready), 64'd0);
      step(); step();
      rst0 = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (if0.rsp_valid) seen++;
         step();
      end
      check("abort_no_rsp", 64'(seen), 64'd0);
      run_vec(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
